fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction-fetch front end for the pipelined RV32I core. It replaces the single-cycle PC register and direct instruction-memory path with a PC generator, a single-outstanding instruction-memory request/grant/response handshake, and an IQ_DEPTH-entry instruction queue feeding the decode stage. It supports redirects from EX (branch/jump) with in-flight response discard, and reports misaligned redirect targets as a fault entry.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- IQ_DEPTH, 4, instruction queue entries; power of two, ≥ 2
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; reset==0 clears all state
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (word aligned)
- imem_gnt  in  1  request accepted when imem_req && imem_gnt
- imem_rvalid  in  1  response valid; in order, ≥1 cycle after acceptance
- imem_rdata  in  32  fetched instruction
- redirect_valid  in  1  EX-stage control-flow change
- redirect_pc  in  32  new fetch PC
- id_valid  out  1  queue head valid (= queue not empty)
- id_ready  in  1  decode accepts head when id_valid && id_ready
- id_inst  out  32  head instruction
- id_pc  out  32  head PC
- id_fault  out  1  head is a misaligned-target fault entry
- iq_count  out  $clog2(IQ_DEPTH+1)  current queue occupancy

## Operation
- State: fetch_pc (32b), pend (1 request outstanding), drop (outstanding response must be discarded), FSM {S_RUN, S_HALT}, queue of {pc, inst, fault} with wrapping rd/wr pointers and count.
- imem_req = (state==S_RUN) && !redirect_valid && (!pend || imem_rvalid) && (count + pend < IQ_DEPTH); imem_addr = fetch_pc.
- Acceptance: fetch_pc <= fetch_pc + 4 (mod 2^32; 0xFFFF_FFFC wraps to 0), pend <= 1, and the request PC is recorded for its response.
- Response with pend && !drop: push {recorded pc, imem_rdata, 0}; pend clears unless a new request is accepted in the same cycle.
- Response with drop: data discarded, drop and pend clear.
- imem_rvalid while !pend: ignored.
- Dequeue on id_valid && id_ready; push and pop in the same cycle leave count unchanged.
- Redirect (highest priority): queue flushed (count=0, pointers reset), any dequeue that cycle is void, fetch_pc <= redirect_pc, drop <= pend && !imem_rvalid (if the response arrives in the redirect cycle it is dropped then and pend clears). No request is issued in the redirect cycle.
- Redirect with redirect_pc[1:0] != 0: after the flush, push one entry {redirect_pc, 32'h0000_0013, 1}; state <= S_HALT. Any in-flight response is still dropped.
- S_HALT: no requests; the queue drains normally. The only exit is an aligned redirect (→ S_RUN). A misaligned redirect in S_HALT pushes a fresh fault entry.

## Timing
- Reset values: fetch_pc=RESET_PC, pend=0, drop=0, state=S_RUN, count=0; outputs imem_req=1 (combinational), imem_addr=RESET_PC, id_valid=0, id_inst=0, id_pc=0, id_fault=0, iq_count=0.
- Reset asserted mid-transaction: all state clears immediately; a response arriving after release is ignored (pend=0).
- Latency: a response is visible at id_* in the cycle after imem_rvalid.
- With a 1-cycle memory and id_ready=1: one instruction per cycle sustained.
- Full: count + pend == IQ_DEPTH deasserts imem_req; it reasserts in the cycle after a dequeue.
- Empty: id_valid=0; id_inst/id_pc hold their last value (don't-care).
- imem_req may drop before grant (on a redirect or credit loss); the memory must not rely on request stickiness.

## Test plan
- Reset release, 1-cycle memory returning addr^32'hA5A5_0000, id_ready=1 → id_pc sequence 0, 4, 8, … one per cycle; id_inst matches; id_fault=0.
- id_ready=0, IQ_DEPTH=4 → exactly 4 pushes, then imem_req=0 and iq_count=4; raise id_ready for 1 cycle → imem_req=1 the next cycle.
- Redirect to 0x100 while one request is pending with response delayed 3 cycles → stale response dropped; first id_pc=0x100, no stale entries.
- Redirect in the same cycle as imem_rvalid → that response is dropped and the next request is issued at redirect_pc in the following cycle.
- Redirect to 0x202 → single entry {0x202, 0x00000013, fault=1}, no imem_req; then redirect to 0x300 → fetch resumes at 0x300.
- fetch_pc=0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; async reset pulsed mid-response → iq_count=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Instruction-fetch front end for the pipelined RV32I core. It generates
// fetch PCs, runs a single-outstanding request/grant/response handshake
// with instruction memory, and buffers returned instructions in an
// IQ_DEPTH-entry queue that feeds decode. EX-stage redirects flush the
// queue and discard any response still in flight. A misaligned redirect
// target turns into one fault entry, and fetching halts until an aligned
// redirect arrives.
//
// Ports
//   clk_i            clock, all state on the rising edge
//   rst_ni           asynchronous active-low reset
//   imem_req_o       fetch request valid (combinational)
//   imem_addr_o      fetch address (word aligned)
//   imem_gnt_i       request accepted when imem_req_o && imem_gnt_i
//   imem_rvalid_i    in-order response valid
//   imem_rdata_i     fetched instruction
//   redirect_valid_i EX-stage control-flow change
//   redirect_pc_i    new fetch PC
//   id_valid_o       queue head valid
//   id_ready_i       decode accepts the head
//   id_inst_o        head instruction
//   id_pc_o          head PC
//   id_fault_o       head is a misaligned-target fault entry
//   iq_count_o       current queue occupancy
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IQ_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    output logic                          imem_req_o,
    output logic [31:0]                   imem_addr_o,
    input  logic                          imem_gnt_i,
    input  logic                          imem_rvalid_i,
    input  logic [31:0]                   imem_rdata_i,
    input  logic                          redirect_valid_i,
    input  logic [31:0]                   redirect_pc_i,
    output logic                          id_valid_o,
    input  logic                          id_ready_i,
    output logic [31:0]                   id_inst_o,
    output logic [31:0]                   id_pc_o,
    output logic                          id_fault_o,
    output logic [$clog2(IQ_DEPTH+1)-1:0] iq_count_o
);

    localparam int CW = $clog2(IQ_DEPTH + 1);
    localparam int PW = $clog2(IQ_DEPTH);

    typedef enum logic {S_RUN, S_HALT} state_e;

    state_e        state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   req_pc_q;     // PC of the outstanding request
    logic          pend_q;
    logic          drop_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    logic [31:0]   pc_mem_q    [IQ_DEPTH];
    logic [31:0]   inst_mem_q  [IQ_DEPTH];
    logic          fault_mem_q [IQ_DEPTH];

    logic          credit_ok;
    logic          accept;
    logic          resp;
    logic          push;
    logic          pop;
    logic          redir_fault;
    logic [31:0]   wr_pc;
    logic [31:0]   wr_inst;

    // An outstanding request already owns a queue slot, so it counts
    // against the free space.
    assign credit_ok = ({1'b0, count_q} + (CW+1)'(pend_q)) < (CW+1)'(IQ_DEPTH);

    // A new request may go out in the same cycle the previous response
    // returns, which is what sustains one fetch per cycle.
    assign imem_req_o  = (state_q == S_RUN) && !redirect_valid_i &&
                         (!pend_q || imem_rvalid_i) && credit_ok;
    assign imem_addr_o = fetch_pc_q;

    assign accept      = imem_req_o && imem_gnt_i;
    assign resp        = imem_rvalid_i && pend_q;
    assign push        = resp && !drop_q && !redirect_valid_i;
    assign pop         = (count_q != '0) && id_ready_i && !redirect_valid_i;
    assign redir_fault = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);

    // Write data: either a returned instruction or the fault entry, which
    // carries a NOP encoding so decode sees a harmless instruction.
    assign wr_pc   = redir_fault ? redirect_pc_i : req_pc_q;
    assign wr_inst = redir_fault ? 32'h0000_0013 : imem_rdata_i;

    genvar gi;
    generate
        for (gi = 0; gi < IQ_DEPTH; gi++) begin : g_entry
            logic wr_en;
            // The flush resets the pointers, so a fault entry always lands in slot 0.
            assign wr_en = (redir_fault && (gi == 0)) ||
                           (push && (wr_ptr_q == PW'(gi)));

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    pc_mem_q[gi]    <= '0;
                    inst_mem_q[gi]  <= '0;
                    fault_mem_q[gi] <= 1'b0;
                end else if (wr_en) begin
                    pc_mem_q[gi]    <= wr_pc;
                    inst_mem_q[gi]  <= wr_inst;
                    fault_mem_q[gi] <= redir_fault;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_RUN;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            pend_q     <= 1'b0;
            drop_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else if (redirect_valid_i) begin
            fetch_pc_q <= redirect_pc_i;
            // A response arriving in the redirect cycle is discarded right
            // away; otherwise the one still in flight is marked for discard.
            pend_q     <= pend_q && !imem_rvalid_i;
            drop_q     <= pend_q && !imem_rvalid_i;
            rd_ptr_q   <= '0;
            if (redir_fault) begin
                wr_ptr_q <= PW'(1);
                count_q  <= CW'(1);
                state_q  <= S_HALT;
            end else begin
                wr_ptr_q <= '0;
                count_q  <= '0;
                state_q  <= S_RUN;
            end
        end else begin
            if (accept) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
                pend_q     <= 1'b1;
                req_pc_q   <= fetch_pc_q;
            end else if (resp) begin
                pend_q <= 1'b0;
            end
            if (resp && drop_q) begin
                drop_q <= 1'b0;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign id_valid_o = (count_q != '0);
    assign id_inst_o  = inst_mem_q[rd_ptr_q];
    assign id_pc_o    = pc_mem_q[rd_ptr_q];
    assign id_fault_o = fault_mem_q[rd_ptr_q];
    assign iq_count_o = count_q;

endmodule
